// File: rtl/shim_threshold_sequencer_pkg.sv
// Purpose: shared state encoding and fault codes for the shim threshold sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shim_threshold_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_ARM     = 3'd2,
        ST_RUNNING = 3'd3,
        ST_HALTED  = 3'd4
    } seq_state_t;

    localparam logic [2:0] FAULT_NONE          = 3'd0;
    localparam logic [2:0] FAULT_CFG_BAD       = 3'd1;
    localparam logic [2:0] FAULT_SETUP_TIMEOUT = 3'd2;
    localparam logic [2:0] FAULT_OVER_THRESH   = 3'd3;
    localparam logic [2:0] FAULT_OVERFLOW      = 3'd4;
    localparam logic [2:0] FAULT_UNDERFLOW     = 3'd5;

endpackage

// File: rtl/shim_threshold_sequencer_if.sv
// Purpose: software control, integrator and amplifier-control signals of one sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels or single-cycle pulses.
interface shim_threshold_sequencer_if;
    logic        sys_en;
    logic [31:0] cfg_window;
    logic [14:0] cfg_threshold;
    logic        integ_setup_done;
    logic        integ_over_thresh;
    logic        integ_err_overflow;
    logic        integ_err_underflow;
    logic        fault_clear;
    logic        integ_resetn;
    logic        integ_enable;
    logic [31:0] integ_window;
    logic [14:0] integ_threshold;
    logic        running;
    logic        shutdown_req;
    logic [2:0]  fault_code;
`ifdef SHIM_THRESH_SEQ_TIMESTAMP_EN
    logic [31:0] fault_time;
`endif

    // Sequencer side.
    modport master (
        input  sys_en, cfg_window, cfg_threshold, integ_setup_done,
               integ_over_thresh, integ_err_overflow, integ_err_underflow, fault_clear,
`ifdef SHIM_THRESH_SEQ_TIMESTAMP_EN
        output fault_time,
`endif
        output integ_resetn, integ_enable, integ_window, integ_threshold,
               running, shutdown_req, fault_code
    );

    // Software / integrator side.
    modport slave (
        output sys_en, cfg_window, cfg_threshold, integ_setup_done,
               integ_over_thresh, integ_err_overflow, integ_err_underflow, fault_clear,
`ifdef SHIM_THRESH_SEQ_TIMESTAMP_EN
        input  fault_time,
`endif
        input  integ_resetn, integ_enable, integ_window, integ_threshold,
               running, shutdown_req, fault_code
    );
endinterface

// File: rtl/shim_threshold_sequencer_fault_latch.sv
// Purpose: priority-encode simultaneous fault requests and hold the first one until cleared.
// Latency: 1 cycle from request to fault_code.
// Backpressure: none; later requests are dropped while a code is held.
module shim_sticky_fault_latch
    import shim_threshold_seq_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       cfg_bad,
    input  logic       setup_timeout,
    input  logic       over_thresh,
    input  logic       overflow,
    input  logic       underflow,
    input  logic       clear,
    output logic [2:0] fault_code
);
    logic [2:0] cand;

    // FIFO errors outrank the threshold flag; the others never coincide with them.
    always_comb begin
        cand = FAULT_NONE;
        if (overflow)           cand = FAULT_OVERFLOW;
        else if (underflow)     cand = FAULT_UNDERFLOW;
        else if (over_thresh)   cand = FAULT_OVER_THRESH;
        else if (setup_timeout) cand = FAULT_SETUP_TIMEOUT;
        else if (cfg_bad)       cand = FAULT_CFG_BAD;
    end

    // First fault is sticky: only an empty register accepts a new code.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                       fault_code <= FAULT_NONE;
        else if (clear)                    fault_code <= FAULT_NONE;
        else if (fault_code == FAULT_NONE) fault_code <= cand;
    end
endmodule

// File: rtl/shim_threshold_sequencer.sv
// Purpose: config check, integrator reset/enable sequencing, setup timeout, first-fault shutdown.
// Latency: outputs registered, 1 cycle after the causing input; optional fault_time via SHIM_THRESH_SEQ_TIMESTAMP_EN.
// Backpressure: none; software must drop sys_en and pulse fault_clear to leave HALTED.
module shim_threshold_sequencer
    import shim_threshold_seq_pkg::*;
#(
    parameter int MIN_WINDOW    = 2048,
    parameter int RST_CYCLES    = 4,
    parameter int SETUP_TIMEOUT = 65536
) (
    input  logic clk,
    input  logic resetn,
    shim_threshold_sequencer_if.master bus
);
    localparam int TW = (SETUP_TIMEOUT > 2) ? $clog2(SETUP_TIMEOUT) : 1;

    seq_state_t  state;
    logic [3:0]  rst_cnt;
    logic [TW-1:0] tmo_cnt;
    logic        integ_resetn_q, integ_enable_q, running_q, shutdown_q;
    logic [31:0] window_q;
    logic [14:0] threshold_q;

    logic cfg_bad_req, timeout_req, run_fault, fault_clr;

    assign cfg_bad_req = (state == ST_IDLE) && bus.sys_en && (bus.cfg_window < 32'(MIN_WINDOW));
    assign timeout_req = (state == ST_ARM) && !bus.integ_setup_done && (tmo_cnt == TW'(SETUP_TIMEOUT - 1));
    assign run_fault   = (state == ST_RUNNING) &&
                         (bus.integ_err_overflow || bus.integ_err_underflow || bus.integ_over_thresh);
    assign fault_clr   = (state == ST_HALTED) && bus.fault_clear && !bus.sys_en;

    shim_sticky_fault_latch u_fault (
        .clk           (clk),
        .resetn        (resetn),
        .cfg_bad       (cfg_bad_req),
        .setup_timeout (timeout_req),
        .over_thresh   ((state == ST_RUNNING) && bus.integ_over_thresh),
        .overflow      ((state == ST_RUNNING) && bus.integ_err_overflow),
        .underflow     ((state == ST_RUNNING) && bus.integ_err_underflow),
        .clear         (fault_clr),
        .fault_code    (bus.fault_code)
    );

    // Sequencer FSM; a fault always beats a simultaneous sys_en drop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            rst_cnt        <= '0;
            tmo_cnt        <= '0;
            integ_resetn_q <= 1'b0;
            integ_enable_q <= 1'b0;
            running_q      <= 1'b0;
            shutdown_q     <= 1'b0;
            window_q       <= '0;
            threshold_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_bad_req) begin
                        state          <= ST_HALTED;
                        shutdown_q     <= 1'b1;
                        integ_resetn_q <= 1'b1;
                    end else if (bus.sys_en) begin
                        state       <= ST_RESET;
                        rst_cnt     <= '0;
                        window_q    <= bus.cfg_window;
                        threshold_q <= bus.cfg_threshold;
                    end
                end
                ST_RESET: begin
                    if (!bus.sys_en) begin
                        state <= ST_IDLE;
                    end else if (rst_cnt == 4'(RST_CYCLES - 1)) begin
                        state          <= ST_ARM;
                        integ_resetn_q <= 1'b1;
                        integ_enable_q <= 1'b1;
                        tmo_cnt        <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 4'd1;
                    end
                end
                ST_ARM: begin
                    if (timeout_req) begin
                        state          <= ST_HALTED;
                        integ_enable_q <= 1'b0;
                        shutdown_q     <= 1'b1;
                    end else if (!bus.sys_en) begin
                        state          <= ST_IDLE;
                        integ_resetn_q <= 1'b0;
                        integ_enable_q <= 1'b0;
                    end else if (bus.integ_setup_done) begin
                        state     <= ST_RUNNING;
                        running_q <= 1'b1;
                    end else begin
                        // Stops at the terminal count, so it cannot wrap.
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (run_fault) begin
                        state          <= ST_HALTED;
                        running_q      <= 1'b0;
                        integ_enable_q <= 1'b0;
                        shutdown_q     <= 1'b1;
                    end else if (!bus.sys_en) begin
                        state          <= ST_IDLE;
                        running_q      <= 1'b0;
                        integ_resetn_q <= 1'b0;
                        integ_enable_q <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    // integ_resetn stays high so the integrator flags remain readable.
                    if (fault_clr) begin
                        state          <= ST_IDLE;
                        shutdown_q     <= 1'b0;
                        integ_resetn_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.integ_resetn    = integ_resetn_q;
    assign bus.integ_enable    = integ_enable_q;
    assign bus.running         = running_q;
    assign bus.shutdown_req    = shutdown_q;
    assign bus.integ_window    = window_q;
    assign bus.integ_threshold = threshold_q;

`ifdef SHIM_THRESH_SEQ_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] fault_time_q;

    // RUNNING cycle counter, zero on entry, saturating; captured on the first run fault.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ts_cnt       <= '0;
            fault_time_q <= '0;
        end else begin
            if (state != ST_RUNNING)      ts_cnt <= '0;
            else if (ts_cnt != '1)        ts_cnt <= ts_cnt + 32'd1;
            if (fault_clr)                fault_time_q <= '0;
            else if (run_fault && bus.fault_code == FAULT_NONE) fault_time_q <= ts_cnt;
        end
    end

    assign bus.fault_time = fault_time_q;
`endif
endmodule

// File: tb/tb_shim_threshold_sequencer.sv
// Purpose: directed self-checking bench for shim_threshold_sequencer (SETUP_TIMEOUT=64).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_shim_threshold_sequencer;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    shim_threshold_sequencer_if bus_if();

    shim_threshold_sequencer #(
        .MIN_WINDOW    (2048),
        .RST_CYCLES    (4),
        .SETUP_TIMEOUT (64)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and wait (bounded) for integ_enable; n returns ticks after the RESET entry edge.
    task automatic start_arm(output int n);
        bus_if.cfg_window    = 32'd4096;
        bus_if.cfg_threshold = 15'd100;
        bus_if.sys_en        = 1'b1;
        tick();
        n = 0;
        while (!bus_if.integ_enable && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic clear_fault();
        bus_if.sys_en = 1'b0;
        tick();
        bus_if.fault_clear = 1'b1;
        tick();
        bus_if.fault_clear = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        int en_seen;
        bus_if.sys_en              = 1'b0;
        bus_if.cfg_window          = '0;
        bus_if.cfg_threshold       = '0;
        bus_if.integ_setup_done    = 1'b0;
        bus_if.integ_over_thresh   = 1'b0;
        bus_if.integ_err_overflow  = 1'b0;
        bus_if.integ_err_underflow = 1'b0;
        bus_if.fault_clear         = 1'b0;
        tick();
        tick();
        chk("rst_integ_resetn", 32'(bus_if.integ_resetn), 0);
        chk("rst_integ_enable", 32'(bus_if.integ_enable), 0);
        chk("rst_window", bus_if.integ_window, 0);
        chk("rst_threshold", 32'(bus_if.integ_threshold), 0);
        chk("rst_running", 32'(bus_if.running), 0);
        chk("rst_shutdown", 32'(bus_if.shutdown_req), 0);
        chk("rst_fault_code", 32'(bus_if.fault_code), 0);
        resetn = 1'b1;
        tick();

        // 1: window below minimum faults at once, enable never rises.
        bus_if.cfg_window = 32'd1000;
        bus_if.sys_en     = 1'b1;
        tick();
        chk("cfg_bad_code", 32'(bus_if.fault_code), 1);
        chk("cfg_bad_shutdown", 32'(bus_if.shutdown_req), 1);
        en_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_if.integ_enable) en_seen = 1;
        end
        chk("cfg_bad_no_enable", 32'(en_seen), 0);
        chk("cfg_bad_window_unlatched", bus_if.integ_window, 0);
        clear_fault();
        chk("cfg_bad_cleared", 32'(bus_if.fault_code), 0);

        // 2: good config, 4-cycle local reset, setup_done after 20 cycles.
        start_arm(n);
        chk("reset_len", 32'(n), 4);
        chk("arm_resetn", 32'(bus_if.integ_resetn), 1);
        chk("arm_window", bus_if.integ_window, 4096);
        chk("arm_threshold", 32'(bus_if.integ_threshold), 100);
        bus_if.cfg_window = 32'd100;   // must be ignored outside IDLE
        repeat (20) tick();
        chk("arm_not_running", 32'(bus_if.running), 0);
        bus_if.integ_setup_done = 1'b1;
        tick();
        bus_if.integ_setup_done = 1'b0;
        chk("running", 32'(bus_if.running), 1);
        chk("running_window_stable", bus_if.integ_window, 4096);

        // 4: simultaneous flags -> overflow wins; later underflow ignored.
        bus_if.integ_err_overflow  = 1'b1;
        bus_if.integ_err_underflow = 1'b1;
        bus_if.integ_over_thresh   = 1'b1;
        tick();
        bus_if.integ_err_overflow = 1'b0;
        bus_if.integ_over_thresh  = 1'b0;
        chk("prio_code", 32'(bus_if.fault_code), 4);
        chk("halt_running", 32'(bus_if.running), 0);
        chk("halt_enable", 32'(bus_if.integ_enable), 0);
        chk("halt_resetn", 32'(bus_if.integ_resetn), 1);
        chk("halt_shutdown", 32'(bus_if.shutdown_req), 1);
        tick();
        bus_if.integ_err_underflow = 1'b0;
        chk("sticky_code", 32'(bus_if.fault_code), 4);

        // 5: clear ignored while sys_en high; honoured after it drops.
        bus_if.fault_clear = 1'b1;
        tick();
        bus_if.fault_clear = 1'b0;
        chk("clr_ignored_code", 32'(bus_if.fault_code), 4);
        chk("clr_ignored_shutdown", 32'(bus_if.shutdown_req), 1);
        bus_if.sys_en = 1'b0;
        tick();
        chk("sys_en_drop_halted", 32'(bus_if.fault_code), 4);
        bus_if.fault_clear = 1'b1;
        tick();
        bus_if.fault_clear = 1'b0;
        chk("clr_code", 32'(bus_if.fault_code), 0);
        chk("clr_shutdown", 32'(bus_if.shutdown_req), 0);
        chk("clr_resetn", 32'(bus_if.integ_resetn), 0);
        bus_if.cfg_window = 32'd4096;

        // 3: setup timeout lands exactly 64 cycles after enable.
        start_arm(n);
        chk("tmo_arm_reached", 32'(bus_if.integ_enable), 1);
        k = 0;
        while (bus_if.fault_code == 3'd0 && k < 200) begin
            tick();
            k++;
        end
        chk("tmo_cycles", 32'(k), 64);
        chk("tmo_code", 32'(bus_if.fault_code), 2);
        chk("tmo_enable", 32'(bus_if.integ_enable), 0);
`ifdef SHIM_THRESH_SEQ_TIMESTAMP_EN
        chk("tmo_fault_time", bus_if.fault_time, 0);
`endif
        clear_fault();

        // sys_en drop in ARM returns to IDLE without a fault.
        start_arm(n);
        bus_if.sys_en = 1'b0;
        tick();
        chk("drop_arm_enable", 32'(bus_if.integ_enable), 0);
        chk("drop_arm_resetn", 32'(bus_if.integ_resetn), 0);
        chk("drop_arm_code", 32'(bus_if.fault_code), 0);
        tick();

`ifdef SHIM_THRESH_SEQ_TIMESTAMP_EN
        // Timestamp: fault presented 37 cycles into RUNNING.
        start_arm(n);
        bus_if.integ_setup_done = 1'b1;
        tick();
        bus_if.integ_setup_done = 1'b0;
        repeat (37) tick();
        bus_if.integ_over_thresh = 1'b1;
        tick();
        bus_if.integ_over_thresh = 1'b0;
        chk("ts_code", 32'(bus_if.fault_code), 3);
        chk("ts_fault_time", bus_if.fault_time, 37);
        clear_fault();
        chk("ts_cleared", bus_if.fault_time, 0);
`endif

        // 6: async reset mid-RUNNING clears every output before the next edge.
        start_arm(n);
        bus_if.integ_setup_done = 1'b1;
        tick();
        bus_if.integ_setup_done = 1'b0;
        chk("pre_reset_running", 32'(bus_if.running), 1);
        repeat (5) tick();
        #2 resetn = 1'b0;
        #1;
        chk("async_running", 32'(bus_if.running), 0);
        chk("async_enable", 32'(bus_if.integ_enable), 0);
        chk("async_resetn", 32'(bus_if.integ_resetn), 0);
        chk("async_window", bus_if.integ_window, 0);
        chk("async_threshold", 32'(bus_if.integ_threshold), 0);
        chk("async_shutdown", 32'(bus_if.shutdown_req), 0);
        chk("async_code", 32'(bus_if.fault_code), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
